seg7_mux_driver: RTL

SEG7_MUX_DRIVER -- requirements
Module: seg7_mux_driver

---
 rtl/seg7_mux_driver_if.sv | 28 ++
 rtl/seg7_mux_driver.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/seg7_mux_driver_if.sv
// Bus bundle for the multiplexed 7-segment driver: display data/strobe in,
// digit enables, segments and frame marker out.
interface seg7_mux_driver_if #(
  parameter int DISP_NUMBER  = 4,
  parameter int BRIGHT_WIDTH = 4
);
  logic [4*DISP_NUMBER-1:0] i_disp_data;
  logic [DISP_NUMBER-1:0]   i_dp;
  logic [DISP_NUMBER-1:0]   i_blank;
  logic                     i_update;
  logic [BRIGHT_WIDTH-1:0]  i_brightness;
  logic [DISP_NUMBER-1:0]   o_disp_enable;
  logic [6:0]               o_segments;
  logic                     o_dp;
  logic                     o_frame_start;

  // Producer of display data, consumer of the panel drive.
  modport master (
    output i_disp_data, i_dp, i_blank, i_update, i_brightness,
    input  o_disp_enable, o_segments, o_dp, o_frame_start
  );

  // The driver itself.
  modport slave (
    input  i_disp_data, i_dp, i_blank, i_update, i_brightness,
    output o_disp_enable, o_segments, o_dp, o_frame_start
  );
endinterface

// File: rtl/seg7_mux_driver.sv
// Time-multiplexed 7-segment display driver with frame-synchronous data
// update, anti-ghosting dead time per digit slot and PWM brightness.
module seg7_mux_driver #(
  parameter int DISP_NUMBER   = 4,
  parameter int CLOCK_DIVIDER = 12_000,
  parameter int DEAD_CYCLES   = 16,
  parameter int BRIGHT_WIDTH  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  seg7_mux_driver_if.slave  bus
);

  localparam int P_W = $clog2(CLOCK_DIVIDER);
  localparam int D_W = (DISP_NUMBER > 1) ? $clog2(DISP_NUMBER) : 1;

  logic [P_W-1:0]           p;
  logic [D_W-1:0]           d;
  logic [BRIGHT_WIDTH-1:0]  q;

  logic [4*DISP_NUMBER-1:0] shadow_data, active_data;
  logic [DISP_NUMBER-1:0]   shadow_dp, shadow_blank;
  logic [DISP_NUMBER-1:0]   active_dp, active_blank;
  logic                     pending;

  logic                     p_wrap;
  logic                     frame_boundary;
  logic                     pwm_on;
  logic                     digit_on;
  logic [3:0]               nibble;
  logic [DISP_NUMBER-1:0]   enable_next;
  logic [6:0]               segments_next;
  logic                     dp_next;

  // Active-low glyphs, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_glyph(input logic [3:0] n);
    case (n)
      4'h0: hex_glyph = 7'h40;
      4'h1: hex_glyph = 7'h79;
      4'h2: hex_glyph = 7'h24;
      4'h3: hex_glyph = 7'h30;
      4'h4: hex_glyph = 7'h19;
      4'h5: hex_glyph = 7'h12;
      4'h6: hex_glyph = 7'h02;
      4'h7: hex_glyph = 7'h78;
      4'h8: hex_glyph = 7'h00;
      4'h9: hex_glyph = 7'h10;
      4'hA: hex_glyph = 7'h08;
      4'hB: hex_glyph = 7'h03;
      4'hC: hex_glyph = 7'h46;
      4'hD: hex_glyph = 7'h21;
      4'hE: hex_glyph = 7'h06;
      default: hex_glyph = 7'h0E;
    endcase
  endfunction

  assign p_wrap         = (p == P_W'(CLOCK_DIVIDER - 1));
  assign frame_boundary = p_wrap && (d == D_W'(DISP_NUMBER - 1));
  assign pwm_on         = (&bus.i_brightness) || (q < bus.i_brightness);
  assign digit_on       = (p >= P_W'(DEAD_CYCLES)) && pwm_on && !active_blank[d];
  assign nibble         = active_data[4*d +: 4];

  // Slot timing: prescaler, digit index and free-running PWM counter.
  always_ff @(posedge i_clk) begin
    // NOTE: non-blocking assignments keep every register sampling the
    // pre-edge values of the others, so ordering inside the block is irrelevant.
    if (i_rst) begin
      p <= '0;
      d <= '0;
      q <= '0;
    end else begin
      q <= q + 1'b1;
      if (p_wrap) begin
        p <= '0;
        d <= frame_boundary ? '0 : d + 1'b1;
      end else begin
        p <= p + 1'b1;
      end
    end
  end

  // Shadow capture on strobe; shadow moves to active only at a frame boundary
  // so a frame is never shown with mixed old and new digits.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      shadow_data  <= '0;
      shadow_dp    <= '0;
      shadow_blank <= '0;
      active_data  <= '0;
      active_dp    <= '0;
      active_blank <= '1;
      pending      <= 1'b0;
    end else begin
      if (frame_boundary && pending) begin
        active_data  <= shadow_data;
        active_dp    <= shadow_dp;
        active_blank <= shadow_blank;
      end
      if (bus.i_update) begin
        shadow_data  <= bus.i_disp_data;
        shadow_dp    <= bus.i_dp;
        shadow_blank <= bus.i_blank;
        pending      <= 1'b1;
      end else if (frame_boundary) begin
        pending      <= 1'b0;
      end
    end
  end

  // Next panel drive derived from the current slot state.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a value held and no latch is inferred.
    enable_next   = '1;
    segments_next = 7'h7F;
    dp_next       = 1'b1;
    if (digit_on) begin
      enable_next[d] = 1'b0;
      segments_next  = hex_glyph(nibble);
      dp_next        = ~active_dp[d];
    end
  end

  // All panel outputs registered together so enables, segments and dp
  // switch on the same edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bus.o_disp_enable <= '1;
      bus.o_segments    <= 7'h7F;
      bus.o_dp          <= 1'b1;
      bus.o_frame_start <= 1'b0;
    end else begin
      bus.o_disp_enable <= enable_next;
      bus.o_segments    <= segments_next;
      bus.o_dp          <= dp_next;
      bus.o_frame_start <= frame_boundary;
    end
  end

endmodule
